seg_scan_decoder: RTL and testbench

Receive side of the multiplexed 7-segment display bus. Watches the active-low segment lines and active-low digit strobes of a 4-digit common-anode scanned display. Inverts the hex-to-segment encoding and rebuilds the 16-bit displayed value. Used in the 8259b bench/board as a display monitor, so captured display contents can be checked against the data driven into the segment encoders.

---
 rtl/seg_scan_decoder_if.sv | 14 +
 rtl/seg_scan_decoder.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
// Signal bundle between the scanned-display lines and the decoder.
// The master drives the segment/strobe lines; the slave returns the rebuilt value.
interface seg_scan_decoder_if;
   logic [6:0]  iSEG;
   logic [3:0]  iDIGSEL;
   logic        iCLR;
   logic [15:0] oHEX;
   logic [3:0]  oVALID;
   logic        oERR;
   logic        oSTB;

   modport master (output iSEG, iDIGSEL, iCLR, input oHEX, oVALID, oERR, oSTB);
   modport slave  (input iSEG, iDIGSEL, iCLR, output oHEX, oVALID, oERR, oSTB);
endinterface

// File: rtl/seg_scan_decoder.sv
// Monitors a 4-digit scanned 7-segment bus and rebuilds the displayed 16-bit value.
// One capture per strobe dwell, after STABLE_CYC identical synchronized samples.
module seg_scan_decoder #(
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              iCLK,
   input  logic              iRST,
   seg_scan_decoder_if.slave bus
);
   // state    | meaning
   // ST_ARMED | current strobe dwell has not been captured yet
   // ST_DONE  | dwell already captured; waiting for a strobe change
   typedef enum logic {ST_ARMED, ST_DONE} state_t;

   localparam logic [7:0]  LP_CAP_CNT  = 8'(STABLE_CYC - 1);
   localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      r_state, w_state_nxt;
   logic [6:0]  r_seg_m, r_seg_s;
   logic [3:0]  r_sel_m, r_sel_s;
   logic [10:0] r_prev;
   logic [7:0]  r_cnt;
   logic [15:0] r_tmo [4];
   logic [15:0] r_hex;
   logic [3:0]  r_valid;
   logic        r_err;
   logic        r_stb;

   logic [3:0]  w_sel_n;
   logic        w_onehot;
   logic        w_same;
   logic        w_sel_chg;
   logic        w_capture;
   logic [1:0]  w_dig;
   logic        w_dec_ok;
   logic [3:0]  w_dec_nib;
   logic [15:0] w_hex_nxt;
   logic [3:0]  w_valid_nxt;
   logic        w_err_nxt;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_seg_m <= '1;
         r_seg_s <= '1;
         r_sel_m <= '1;
         r_sel_s <= '1;
      end else begin
         r_seg_m <= bus.iSEG;
         r_seg_s <= r_seg_m;
         r_sel_m <= bus.iDIGSEL;
         r_sel_s <= r_sel_m;
      end
   end

   assign w_sel_n   = ~r_sel_s;
   assign w_onehot  = (w_sel_n != 4'd0) && ((w_sel_n & (w_sel_n - 4'd1)) == 4'd0);
   assign w_same    = ({r_seg_s, r_sel_s} == r_prev);
   assign w_sel_chg = (r_sel_s != r_prev[3:0]);
   assign w_capture = (r_state == ST_ARMED) && (r_cnt == LP_CAP_CNT);

   // r_prev always holds the sample that r_cnt describes, so it is what gets decoded
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_prev <= '1;
         r_cnt  <= '0;
      end else begin
         r_prev <= {r_seg_s, r_sel_s};
         if (!w_same || !w_onehot)
            r_cnt <= '0;
         else if (r_cnt != 8'hff)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) r_state <= ST_ARMED;
      else      r_state <= w_state_nxt;
   end

   // a strobe change starting a new dwell beats a capture finishing the old one
   always_comb begin
      w_state_nxt = r_state;
      if (w_sel_chg)
         w_state_nxt = ST_ARMED;
      else if (w_capture)
         w_state_nxt = ST_DONE;
   end

   always_comb begin
      w_dig = 2'd0;
      case (r_prev[3:0])
         4'b1110: w_dig = 2'd0;
         4'b1101: w_dig = 2'd1;
         4'b1011: w_dig = 2'd2;
         4'b0111: w_dig = 2'd3;
         default: w_dig = 2'd0;
      endcase
   end

   always_comb begin
      w_dec_ok  = 1'b1;
      w_dec_nib = 4'h0;
      case (r_prev[10:4])
         7'b1000000: w_dec_nib = 4'h0;
         7'b1111001: w_dec_nib = 4'h1;
         7'b0100100: w_dec_nib = 4'h2;
         7'b0110000: w_dec_nib = 4'h3;
         7'b0011001: w_dec_nib = 4'h4;
         7'b0010010: w_dec_nib = 4'h5;
         7'b0000010: w_dec_nib = 4'h6;
         7'b1111000: w_dec_nib = 4'h7;
         7'b0000000: w_dec_nib = 4'h8;
         7'b0011000: w_dec_nib = 4'h9;
         7'b0001000: w_dec_nib = 4'hA;
         7'b0000011: w_dec_nib = 4'hB;
         7'b1000110: w_dec_nib = 4'hC;
         7'b0100001: w_dec_nib = 4'hD;
         7'b0000110: w_dec_nib = 4'hE;
         7'b0001110: w_dec_nib = 4'hF;
         default:    w_dec_ok  = 1'b0;
      endcase
   end

   // timeout first, capture last, so a same-cycle capture keeps the digit valid
   always_comb begin
      w_hex_nxt   = r_hex;
      w_valid_nxt = r_valid;
      w_err_nxt   = r_err & ~bus.iCLR;
      for (int n = 0; n < 4; n++)
         if (r_tmo[n] >= LP_TMO_LAST) w_valid_nxt[n] = 1'b0;
      if (w_capture) begin
         if (w_dec_ok) begin
            w_hex_nxt[{w_dig, 2'b00} +: 4] = w_dec_nib;
            w_valid_nxt[w_dig]             = 1'b1;
         end else begin
            w_valid_nxt[w_dig] = 1'b0;
            if (r_prev[10:4] != 7'h7f) w_err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int n = 0; n < 4; n++) r_tmo[n] <= '0;
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (w_capture && (w_dig == 2'(n)))
               r_tmo[n] <= '0;
            else if (r_tmo[n] != 16'hffff)
               r_tmo[n] <= r_tmo[n] + 16'd1;
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_hex   <= '0;
         r_valid <= '0;
         r_err   <= 1'b0;
         r_stb   <= 1'b0;
      end else begin
         r_hex   <= w_hex_nxt;
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
         r_stb   <= (w_hex_nxt != r_hex) || (w_valid_nxt != r_valid);
      end
   end

   assign bus.oHEX   = r_hex;
   assign bus.oVALID = r_valid;
   assign bus.oERR   = r_err;
   assign bus.oSTB   = r_stb;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed dwell table with hand-derived end states,
// a reset-latency sequence, and random scanning checked every cycle against a history model.
module tb_seg_scan_decoder;
   localparam int SC    = 4;
   localparam int TO    = 100;
   localparam int HMAX  = 8192;
   localparam int NROWS = 26;

   localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111;
   localparam logic [6:0] S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19, S5 = 7'h12;
   localparam logic [6:0] S7 = 7'h78, S8 = 7'h00, SA = 7'h08, SB = 7'h03, SCC = 7'h46;
   localparam logic [6:0] SD = 7'h21, BAD = 7'h55;

   typedef struct {
      logic [3:0]  sel;
      logic [6:0]  seg;
      int          dwell;
      int          glitch_at;
      int          clr_at;
      logic [15:0] exp_hex;
      logic [3:0]  exp_val;
      logic        exp_err;
      int          exp_stb;
   } row_t;

   logic iCLK = 1'b0;
   logic iRST = 1'b1;
   seg_scan_decoder_if bus();

   seg_scan_decoder #(.STABLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   always #5 iCLK = ~iCLK;

   int checks   = 0;
   int failures = 0;
   int stb_seen = 0;

   row_t       rows [NROWS];
   logic [6:0] seg_tab [16];

   // history model: pin samples since the last reset release
   logic [6:0]  h_seg [HMAX];
   logic [3:0]  h_sel [HMAX];
   int          h_dw  [HMAX];
   int          m_e, m_dw, m_capdw;
   logic [3:0]  m_nib [4];
   bit          m_vf  [4];
   int          m_ce  [4];
   bit          m_err;
   logic [15:0] e_hex;
   logic [3:0]  e_val;
   logic        e_err, e_stb;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, got, exp);
      end
   endtask

   function automatic logic [10:0] samp(input int j);
      if (j < 0) return 11'h7ff;
      return {h_seg[j], h_sel[j]};
   endfunction

   function automatic bit onehot_low(input logic [3:0] s);
      int z = 0;
      for (int i = 0; i < 4; i++) if (!s[i]) z++;
      return z == 1;
   endfunction

   function automatic int digit_of(input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (!s[i]) return i;
      return 0;
   endfunction

   task automatic decode(input logic [6:0] seg, output bit found, output logic [3:0] nib);
      found = 0;
      nib   = 4'h0;
      for (int i = 0; i < 16; i++)
         if (seg_tab[i] == seg) begin
            found = 1;
            nib   = 4'(i);
         end
   endtask

   task automatic model_reset();
      m_e = 0; m_dw = 0; m_capdw = -1; m_err = 0;
      for (int i = 0; i < 4; i++) begin
         m_nib[i] = 4'h0; m_vf[i] = 0; m_ce[i] = 0;
      end
      e_hex = '0; e_val = '0; e_err = 1'b0; e_stb = 1'b0;
   endtask

   task automatic model_edge(input logic [6:0] seg, input logic [3:0] sel, input logic clr);
      int          e, j0, n;
      bit          hit, found;
      logic [10:0] s0, sj, sp;
      logic [3:0]  psel, nib, vl;
      logic [15:0] hx;
      e = m_e;
      if (e >= HMAX) begin
         $display("FAIL history_overflow actual=%0d required<%0d", e, HMAX);
         $fatal(1, "history overflow");
      end
      h_seg[e] = seg;
      h_sel[e] = sel;
      sp   = samp(e - 1);
      psel = sp[3:0];
      if (sel != psel) m_dw++;
      h_dw[e] = m_dw;
      if (clr) m_err = 0;
      // a capture at edge e needs the SC samples ending at e-3 to form a fresh run
      j0  = e - 2 - SC;
      hit = 0;
      s0  = '1;
      if (j0 >= 0) begin
         s0  = samp(j0);
         hit = 1;
         for (int j = j0 + 1; j <= e - 3; j++) begin
            sj = samp(j);
            if (sj != s0) hit = 0;
         end
         sp = samp(j0 - 1);
         if (sp == s0) hit = 0;
         if (!onehot_low(s0[3:0])) hit = 0;
         if (h_dw[e-3] == m_capdw) hit = 0;
      end
      if (hit) begin
         m_capdw = h_dw[e-3];
         n       = digit_of(s0[3:0]);
         m_ce[n] = e;
         decode(s0[10:4], found, nib);
         if (found) begin
            m_nib[n] = nib;
            m_vf[n]  = 1;
         end else begin
            m_vf[n] = 0;
            if (s0[10:4] != 7'h7f) m_err = 1;
         end
      end
      hx = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      for (int i = 0; i < 4; i++) vl[i] = m_vf[i] && ((e - m_ce[i]) < TO);
      e_stb = (hx != e_hex) || (vl != e_val);
      e_hex = hx;
      e_val = vl;
      e_err = m_err;
      m_e++;
   endtask

   task automatic step(input logic [6:0] seg, input logic [3:0] sel, input logic clr);
      bus.iSEG    = seg;
      bus.iDIGSEL = sel;
      bus.iCLR    = clr;
      @(posedge iCLK);
      #1;
      if (iRST) model_reset();
      else      model_edge(seg, sel, clr);
      chk("hex",   32'(bus.oHEX),   32'(e_hex));
      chk("valid", 32'(bus.oVALID), 32'(e_val));
      chk("err",   32'(bus.oERR),   32'(e_err));
      chk("stb",   32'(bus.oSTB),   32'(e_stb));
      if (bus.oSTB) stb_seen++;
   endtask

   initial begin
      int         found;
      logic [6:0] seg;
      logic [3:0] sel;
      int         len, pick;

      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      rows[0]  = '{D3, S1,  20, -1, -1, 16'h1000, 4'b1000, 1'b0, 1};
      rows[1]  = '{D2, S2,  20, -1, -1, 16'h1200, 4'b1100, 1'b0, 1};
      rows[2]  = '{D1, S3,  20, -1, -1, 16'h1230, 4'b1110, 1'b0, 1};
      rows[3]  = '{D0, S4,  20, -1, -1, 16'h1234, 4'b1111, 1'b0, 1};
      rows[4]  = '{D3, S1,  20, -1, -1, 16'h1234, 4'b1111, 1'b0, 0};
      rows[5]  = '{D2, S2,  20, -1, -1, 16'h1234, 4'b1111, 1'b0, 0};
      rows[6]  = '{D1, S3,  20, -1, -1, 16'h1234, 4'b1111, 1'b0, 0};
      rows[7]  = '{D0, S4,  20, -1, -1, 16'h1234, 4'b1111, 1'b0, 0};
      rows[8]  = '{D3, S1,  20, -1, -1, 16'h1234, 4'b1111, 1'b0, 0};
      rows[9]  = '{D2, S2,  20, -1, -1, 16'h1234, 4'b1111, 1'b0, 0};
      rows[10] = '{D1, S3,  20, -1, -1, 16'h1234, 4'b1111, 1'b0, 0};
      rows[11] = '{D0, S7,  20, 10, -1, 16'h1237, 4'b1111, 1'b0, 1};
      rows[12] = '{D3, S1,  20, -1, -1, 16'h1237, 4'b1111, 1'b0, 0};
      rows[13] = '{D2, BAD, 10, -1, -1, 16'h1237, 4'b1011, 1'b1, 1};
      rows[14] = '{D1, S3,  20, -1, -1, 16'h1237, 4'b1011, 1'b1, 0};
      rows[15] = '{D0, S7,  20, -1, -1, 16'h1237, 4'b1011, 1'b1, 0};
      rows[16] = '{D3, S1,  20, -1,  2, 16'h1237, 4'b1011, 1'b0, 0};
      rows[17] = '{D2, BAD, 10, -1,  6, 16'h1237, 4'b1011, 1'b1, 0};
      rows[18] = '{D1, S3,  20, -1, -1, 16'h1237, 4'b1011, 1'b1, 0};
      rows[19] = '{D0, S7,  20, -1, -1, 16'h1237, 4'b1011, 1'b1, 0};
      rows[20] = '{D3, SA,  20, -1, -1, 16'hA237, 4'b1011, 1'b1, 1};
      rows[21] = '{D2, SB,  20, -1, -1, 16'hAB37, 4'b1111, 1'b1, 1};
      rows[22] = '{D1, SCC, 20, -1, -1, 16'hABC7, 4'b1111, 1'b1, 1};
      rows[23] = '{D0, SD,  20, -1, -1, 16'hABCD, 4'b1111, 1'b1, 1};
      rows[24] = '{4'b1111, S8, 120, -1, -1, 16'hABCD, 4'b0000, 1'b1, 4};
      rows[25] = '{4'b1100, S1,  30, -1, -1, 16'hABCD, 4'b0000, 1'b1, 0};

      bus.iSEG = 7'h7f; bus.iDIGSEL = 4'hf; bus.iCLR = 1'b0;
      model_reset();

      // reset held with random pins
      for (int k = 0; k < 3; k++)
         step(7'($urandom), 4'($urandom), 1'($urandom));
      iRST = 1'b0;

      // directed dwell table
      for (int r = 0; r < NROWS; r++) begin
         stb_seen = 0;
         for (int k = 0; k < rows[r].dwell; k++) begin
            seg = rows[r].seg;
            if (rows[r].glitch_at >= 0 && k >= rows[r].glitch_at && k < rows[r].glitch_at + 2)
               seg = 7'h00;
            step(seg, rows[r].sel, k == rows[r].clr_at);
         end
         chk($sformatf("row%0d_hex", r),   32'(bus.oHEX),   32'(rows[r].exp_hex));
         chk($sformatf("row%0d_valid", r), 32'(bus.oVALID), 32'(rows[r].exp_val));
         chk($sformatf("row%0d_err", r),   32'(bus.oERR),   32'(rows[r].exp_err));
         chk($sformatf("row%0d_stb_count", r), 32'(stb_seen), 32'(rows[r].exp_stb));
      end

      // reset during the third cycle of a dwell, then capture latency after release
      for (int k = 0; k < 3; k++) step(S5, D1, 1'b0);
      iRST = 1'b1;
      #1;
      chk("async_rst_hex",   32'(bus.oHEX),   32'h0);
      chk("async_rst_valid", 32'(bus.oVALID), 32'h0);
      chk("async_rst_err",   32'(bus.oERR),   32'h0);
      chk("async_rst_stb",   32'(bus.oSTB),   32'h0);
      step(S5, D1, 1'b0);
      step(S5, D1, 1'b0);
      iRST  = 1'b0;
      found = -1;
      for (int k = 0; k < 20 && found < 0; k++) begin
         step(S5, D1, 1'b0);
         if (bus.oHEX == 16'h0050 && bus.oVALID == 4'b0010) found = k;
      end
      chk("post_rst_capture_edge", 32'(found), 32'(SC + 2));

      // random scanning against the history model
      for (int d = 0; d < 250; d++) begin
         pick = $urandom_range(0, 99);
         if (pick < 70)      sel = ~(4'b0001 << $urandom_range(0, 3));
         else if (pick < 85) sel = 4'hf;
         else                sel = 4'($urandom);
         pick = $urandom_range(0, 99);
         if (pick < 60)      seg = seg_tab[$urandom_range(0, 15)];
         else if (pick < 75) seg = 7'h7f;
         else                seg = 7'($urandom);
         len = $urandom_range(1, 25);
         for (int k = 0; k < len; k++)
            step(seg, sel, $urandom_range(0, 19) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
